// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if
//
// Groups the control FSM's opcode/handshake inputs and its per-state datapath
// controls into one bundle.
//
// Signals:
//   op         [6:0]  opcode field of the instruction register
//   MemReady          memory access complete
//   PCUpdate          PC write strobe
//   Branch            conditional PC write (datapath ANDs with Zero)
//   RegWrite          register file write
//   MemWrite          data memory write
//   IRWrite           instruction/OldPC register write
//   MemReq            memory request
//   AdrSrc            0 = PC, 1 = Result as memory address
//   ResultSrc  [1:0]  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   ALUSrcA    [1:0]  00 PC, 01 OldPC, 10 rs1 data
//   ALUSrcB    [1:0]  00 rs2 data, 01 ImmExt, 10 constant 4
//   ALUOp      [1:0]  00 add, 01 sub/compare, 10 funct-decoded
//   Illegal           high while trapped on an illegal opcode
//   State      [3:0]  current state encoding (debug)
//
// Modports:
//   master  controller side (drives the controls)
//   slave   datapath side (drives op and MemReady)

interface multicycle_ctrl_fsm_if;

    logic [6:0] op;
    logic       MemReady;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemReq;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  op,
        input  MemReady,
        output PCUpdate,
        output Branch,
        output RegWrite,
        output MemWrite,
        output IRWrite,
        output MemReq,
        output AdrSrc,
        output ResultSrc,
        output ALUSrcA,
        output ALUSrcB,
        output ALUOp,
        output Illegal,
        output State
    );

    modport slave (
        output op,
        output MemReady,
        input  PCUpdate,
        input  Branch,
        input  RegWrite,
        input  MemWrite,
        input  IRWrite,
        input  MemReq,
        input  AdrSrc,
        input  ResultSrc,
        input  ALUSrcA,
        input  ALUSrcB,
        input  ALUOp,
        input  Illegal,
        input  State
    );

endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//
// Main control state machine of the multicycle RISC-V datapath. Steps each
// instruction through fetch / decode / execute / memory / writeback and issues
// the per-state datapath controls. Optionally stalls the memory states on a
// MemReady handshake and traps illegal opcodes.
//
// Parameters:
//   MEM_HANDSHAKE  0: memory completes in one cycle, MemReady ignored
//                  1: FETCH/MEMREAD/MEMWRITE hold until MemReady=1
//   TRAP_HALT      1: TRAP is terminal until reset
//                  0: TRAP lasts one cycle, then FETCH
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      control bundle (master side), see multicycle_ctrl_fsm_if

module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_HANDSHAKE = 0,
    parameter int unsigned TRAP_HALT     = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_ctrl_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StLui      = 4'd11,
        StTrap     = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic       mem_req;
        logic       illegal;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [6:0] OpLw    = 7'b0000011;
    localparam logic [6:0] OpSw    = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpLui   = 7'b0110111;

    localparam bit UseHandshake = (MEM_HANDSHAKE != 0);
    localparam bit HaltOnTrap   = (TRAP_HALT != 0);

    // Moore control decode for one state; unlisted outputs stay 0.
    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.mem_req    = 1'b1;
                c.ir_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            StDecode: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            StMemRead: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            StMemWb: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            StMemWrite: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            StExecR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            StExecI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            StAluWb: begin
                c.reg_write = 1'b1;
            end
            StBeq: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            StJal: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            StLui: begin
                c.result_src = 2'b11;
                c.reg_write  = 1'b1;
            end
            StTrap: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   mem_done;
    logic   in_fetch;

    // Without the handshake every memory access completes in its first cycle.
    assign mem_done = !UseHandshake || bus.MemReady;
    assign in_fetch = (state_q == StFetch);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (mem_done) state_d = StDecode;
            end
            StDecode: begin
                case (bus.op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRType:    state_d = StExecR;
                    OpIType:    state_d = StExecI;
                    OpBeq:      state_d = StBeq;
                    OpJal:      state_d = StJal;
                    OpLui:      state_d = StLui;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAdr:   state_d = (bus.op == OpLw) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (mem_done) state_d = StMemWb;
            end
            StMemWb:    state_d = StFetch;
            StMemWrite: begin
                if (mem_done) state_d = StFetch;
            end
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            StLui:      state_d = StFetch;
            StTrap:     state_d = HaltOnTrap ? StTrap : StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Controls are registered alongside the state, decoded from the state
    // being entered, so they are glitch-free Moore outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            ctrl_q  <= decode(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

    // Strobes are qualified by reset_n so nothing writes while reset is held,
    // even though the registered bundle already carries the FETCH values.
    // IRWrite/PCUpdate in FETCH also wait for MemReady so the PC steps once per
    // fetch however long the memory stalls.
    assign bus.PCUpdate  = ctrl_q.pc_update & reset_n & (!in_fetch || mem_done);
    assign bus.IRWrite   = ctrl_q.ir_write & reset_n & mem_done;
    assign bus.Branch    = ctrl_q.branch & reset_n;
    assign bus.RegWrite  = ctrl_q.reg_write & reset_n;
    assign bus.MemWrite  = ctrl_q.mem_write & reset_n;
    assign bus.MemReq    = ctrl_q.mem_req & reset_n;
    assign bus.Illegal   = ctrl_q.illegal & reset_n;
    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm. Three instances cover the parameter
// corners: u_dut0 (no handshake, halting trap), u_dut1 (handshake, halting
// trap), u_dut2 (no handshake, one-cycle trap). Expected per-cycle state and
// control vectors are queued as stimulus is planned and popped as the selected
// instance is sampled.

module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OpLw    = 7'b0000011;
    localparam logic [6:0] OpSw    = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpBad   = 7'b1111111;

    // {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,MemReq,Illegal,AdrSrc,
    //  ResultSrc,ALUSrcA,ALUSrcB,ALUOp}; reset: FETCH selects, strobes 0
    localparam logic [15:0] RstCtrl = {7'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};

    typedef struct {
        int          dut;
        string       name;
        logic [6:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if if0 ();
    multicycle_ctrl_fsm_if if1 ();
    multicycle_ctrl_fsm_if if2 ();

    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(0), .TRAP_HALT(1)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0.master)
    );
    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(1), .TRAP_HALT(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1.master)
    );
    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(0), .TRAP_HALT(0)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if2.master)
    );

    logic [15:0] v0, v1, v2;
    assign v0 = {if0.PCUpdate, if0.Branch, if0.RegWrite, if0.MemWrite, if0.IRWrite,
                 if0.MemReq, if0.Illegal, if0.AdrSrc, if0.ResultSrc, if0.ALUSrcA,
                 if0.ALUSrcB, if0.ALUOp};
    assign v1 = {if1.PCUpdate, if1.Branch, if1.RegWrite, if1.MemWrite, if1.IRWrite,
                 if1.MemReq, if1.Illegal, if1.AdrSrc, if1.ResultSrc, if1.ALUSrcA,
                 if1.ALUSrcB, if1.ALUOp};
    assign v2 = {if2.PCUpdate, if2.Branch, if2.RegWrite, if2.MemWrite, if2.IRWrite,
                 if2.MemReq, if2.Illegal, if2.AdrSrc, if2.ResultSrc, if2.ALUSrcA,
                 if2.ALUSrcB, if2.ALUOp};

    int          sel;
    logic [3:0]  obs_state;
    logic [15:0] obs_ctrl;

    always_comb begin
        obs_state = if0.State;
        obs_ctrl  = v0;
        case (sel)
            1: begin obs_state = if1.State; obs_ctrl = v1; end
            2: begin obs_state = if2.State; obs_ctrl = v2; end
            default: ;
        endcase
    end

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   aligned  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected controls straight from the per-state output table.
    function automatic logic [15:0] exp_ctrl(input int st, input bit hs, input bit rdy);
        logic pc, br, rw, mw, ir, mreq, ill, adr;
        logic [1:0] res, a, b, aop;
        logic g;
        g = !hs || rdy;
        {pc, br, rw, mw, ir, mreq, ill, adr} = 8'b0;
        {res, a, b, aop} = 8'b0;
        case (st)
            0:  begin mreq = 1; ir = g; pc = g; b = 2'b10; res = 2'b10; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  begin mreq = 1; adr = 1; end
            4:  begin res = 2'b01; rw = 1; end
            5:  begin mreq = 1; adr = 1; mw = 1; end
            6:  begin a = 2'b10; aop = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            8:  begin rw = 1; end
            9:  begin a = 2'b10; aop = 2'b01; br = 1; end
            10: begin a = 2'b01; b = 2'b10; pc = 1; end
            11: begin res = 2'b11; rw = 1; end
            12: begin ill = 1; end
            default: ;
        endcase
        return {pc, br, rw, mw, ir, mreq, ill, adr, res, a, b, aop};
    endfunction

    // op only matters in DECODE/MEMADR; drive junk elsewhere to show it is ignored.
    task automatic push_entry(input int dut, input string name, input logic [6:0] op,
                              input int st, input bit rdy);
        exp_t e;
        e.dut  = dut;
        e.name = name;
        e.op   = (st == 1 || st == 2) ? op : OpBad;
        e.rdy  = rdy;
        e.st   = 4'(st);
        e.ctrl = exp_ctrl(st, dut == 1, rdy);
        sb.push_back(e);
    endtask

    // seq holds one state per nibble, first state in the lowest nibble.
    task automatic push_seq(input int dut, input string name, input logic [6:0] op,
                            input int n, input logic [63:0] seq);
        for (int i = 0; i < n; i++) push_entry(dut, name, op, int'(seq[4*i +: 4]), 1'b1);
    endtask

    task automatic drive_in(input int dut, input logic [6:0] op, input logic rdy);
        case (dut)
            0: begin if0.op = op; if0.MemReady = rdy; end
            1: begin if1.op = op; if1.MemReady = rdy; end
            default: begin if2.op = op; if2.MemReady = rdy; end
        endcase
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!aligned) @(negedge clk);
            aligned = 1'b0;
            sel = e.dut;
            drive_in(e.dut, e.op, e.rdy);
            #1;
            check_val($sformatf("d%0d %s state", e.dut, e.name), 32'(obs_state), 32'(e.st));
            check_val($sformatf("d%0d %s st%0d ctrl", e.dut, e.name, e.st),
                      32'(obs_ctrl), 32'(e.ctrl));
        end
    endtask

    // Asserts reset inside the current low clock phase, checks the immediate
    // asynchronous effect, holds for 3 cycles, then releases just before a
    // rising edge so the next drained entry is the first FETCH cycle.
    task automatic do_reset(input int dut);
        sel = dut;
        drive_in(dut, OpRType, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check_val($sformatf("d%0d rst_async state", dut), 32'(obs_state), 32'd0);
        check_val($sformatf("d%0d rst_async ctrl", dut), 32'(obs_ctrl), 32'(RstCtrl));
        repeat (3) begin
            @(negedge clk);
            #1;
            check_val($sformatf("d%0d rst_hold state", dut), 32'(obs_state), 32'd0);
            check_val($sformatf("d%0d rst_hold ctrl", dut), 32'(obs_ctrl), 32'(RstCtrl));
        end
        reset_n = 1'b1;
        aligned = 1'b1;
    endtask

    initial begin
        sel = 0;
        drive_in(0, OpRType, 1'b0);
        drive_in(1, OpRType, 1'b0);
        drive_in(2, OpRType, 1'b0);
        #2;

        // No handshake, halting trap.
        do_reset(0);
        push_seq(0, "rtype", OpRType, 4, 64'h8610);
        push_seq(0, "lw",    OpLw,    5, 64'h43210);
        push_seq(0, "sw",    OpSw,    4, 64'h5210);
        push_seq(0, "itype", OpIType, 4, 64'h8710);
        push_seq(0, "beq",   OpBeq,   3, 64'h910);
        push_seq(0, "jal",   OpJal,   4, 64'h8A10);
        push_seq(0, "lui",   OpLui,   3, 64'hB10);
        push_seq(0, "lw_abort", OpLw, 4, 64'h3210);
        drain();
        do_reset(0);
        push_seq(0, "trap_halt", OpBad, 8, 64'hCCCCCC10);
        drain();
        do_reset(0);
        push_seq(0, "post_trap", OpLui, 4, 64'h0B10);
        drain();

        // Handshake: fetch stalls twice, MEMWRITE stalls three times.
        do_reset(1);
        push_entry(1, "sw_hs", OpSw, 0, 1'b0);
        push_entry(1, "sw_hs", OpSw, 0, 1'b0);
        push_entry(1, "sw_hs", OpSw, 0, 1'b1);
        push_entry(1, "sw_hs", OpSw, 1, 1'b0);
        push_entry(1, "sw_hs", OpSw, 2, 1'b0);
        for (int i = 0; i < 3; i++) push_entry(1, "sw_hs", OpSw, 5, 1'b0);
        push_entry(1, "sw_hs", OpSw, 5, 1'b1);
        push_entry(1, "lw_hs", OpLw, 0, 1'b1);
        push_entry(1, "lw_hs", OpLw, 1, 1'b0);
        push_entry(1, "lw_hs", OpLw, 2, 1'b0);
        push_entry(1, "lw_hs", OpLw, 3, 1'b0);
        push_entry(1, "lw_hs", OpLw, 3, 1'b1);
        push_entry(1, "lw_hs", OpLw, 4, 1'b0);
        push_entry(1, "fetch_hs", OpLw, 0, 1'b0);
        push_entry(1, "fetch_hs", OpLw, 0, 1'b1);
        push_entry(1, "fetch_hs", OpLw, 1, 1'b0);
        drain();

        // One-cycle trap resumes fetching.
        do_reset(2);
        push_seq(2, "trap_pulse", OpBad, 3, 64'hC10);
        push_seq(2, "lui",        OpLui, 3, 64'hB10);
        push_seq(2, "beq",        OpBeq, 4, 64'h0910);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

- Main control state machine for the multicycle RISC-V datapath.
- Replaces the single-cycle opcode decoder: steps each instruction through fetch, decode, execute, memory and writeback states, and issues per-state datapath controls.
- Adds two things the single-cycle decoder lacks: an optional memory ready/request handshake that stalls memory states, and an illegal-opcode trap with selectable halt behaviour.
- Sits beside the ALU decoder and immediate-select decoder inside the multicycle controller.

## Interface
Parameters:
- MEM_HANDSHAKE, default 0: 0 = memory completes in one cycle (MemReady ignored); 1 = FETCH/MEMREAD/MEMWRITE hold until MemReady=1.
- TRAP_HALT, default 1: 1 = TRAP is terminal until reset; 0 = TRAP lasts one cycle, then FETCH.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  7  opcode field of the instruction register
- MemReady  in  1  memory access complete (used only when MEM_HANDSHAKE=1)
- PCUpdate  out  1  PC write strobe
- Branch  out  1  conditional PC write (datapath ANDs with Zero)
- RegWrite  out  1  register file write
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction/OldPC register write
- MemReq  out  1  memory request, high in FETCH/MEMREAD/MEMWRITE
- AdrSrc  out  1  0 = PC, 1 = Result as memory address
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data
- ALUSrcB  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
- Illegal  out  1  high while in TRAP
- State  out  4  current state encoding (debug)

## Operation
State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11, TRAP=12. Codes 13–15 go to FETCH on the next edge.

Transitions:
- FETCH → DECODE.
- DECODE by op:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 0110111 → LUI
  - any other opcode → TRAP
- MEMADR → MEMREAD if op=lw, else MEMWRITE.
- MEMREAD → MEMWB; MEMWB → FETCH; MEMWRITE → FETCH.
- EXECR, EXECI → ALUWB; ALUWB → FETCH.
- BEQ → FETCH; LUI → FETCH; JAL → ALUWB.
- TRAP → TRAP if TRAP_HALT=1, else FETCH.

Outputs per state (Moore). Any output not listed is 0; don't-care muxes drive 00/0.
- FETCH: MemReq=1, AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: MemReq=1, AdrSrc=1, ResultSrc=00, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- LUI: ResultSrc=11, RegWrite=1.
- TRAP: Illegal=1; all strobes 0.

Handshake (MEM_HANDSHAKE=1):
- FETCH, MEMREAD and MEMWRITE advance only on an edge with MemReady=1; otherwise they hold.
- In FETCH, IRWrite and PCUpdate are gated by MemReady (Mealy), so the PC advances exactly once per fetch.
- MemWrite and MemReq stay high for the whole MEMWRITE stall.
- MemReady is ignored in all other states.

## Timing
- Reset:
  - reset_n low → state=FETCH immediately, asynchronously.
  - While reset_n=0, all strobes (PCUpdate, Branch, RegWrite, MemWrite, IRWrite, MemReq, Illegal) are forced to 0.
  - Mux selects take FETCH values; State=0.
  - The first fetch happens on the first rising edge after reset_n rises.
- Reset mid-instruction aborts it; no partial writes follow.
- Latency with no stalls (MEM_HANDSHAKE=0):
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq, lui: 3 cycles
- Each handshake stall cycle adds 1 cycle.
- op is sampled only in DECODE and MEMADR; op changes elsewhere have no effect.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with op=0110011 → State=0, all strobes 0. Release → IRWrite=PCUpdate=1 in the first cycle, State=1 at the next edge.
- lw, MEM_HANDSHAKE=0: op=0000011 → State sequence 0,1,2,3,4,0. RegWrite=1 with ResultSrc=01 only in state 4. AdrSrc=1 in state 3.
- sw, MEM_HANDSHAKE=1, MemReady low for 3 cycles in MEMWRITE → State holds at 5 for 4 cycles with MemWrite=MemReq=1, then 0. In FETCH with MemReady=0 for 2 cycles, PCUpdate pulses once.
- Branch/jump/lui:
  - beq → 0,1,9,0 with Branch=1 and ALUOp=01.
  - jal → 0,1,10,8,0 with PCUpdate=1 in state 10.
  - lui → 0,1,11,0 with ResultSrc=11.
- Illegal op=1111111:
  - TRAP_HALT=1 → State=12 and Illegal=1 indefinitely, until reset_n=0.
  - TRAP_HALT=0 → Illegal pulses for 1 cycle, then State=0.
- Asynchronous reset asserted mid-cycle in state 3 → State=0 immediately, before the next edge, with RegWrite=0.
